// File: rtl/bdcpu_pkg.sv
// Shared bdcpu definitions: control-unit opcodes for the call/return
// instructions and the default width of the shared CPU bus.
package bdcpu_pkg;

  localparam logic [3:0] OP_CALL = 4'b1001;
  localparam logic [3:0] OP_RET  = 4'b1010;

  localparam int BUS_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/bdcpu_lifo_stack.sv
// Return-address LIFO. The caller must not push when full or pop when empty;
// only the level is reset, entry contents are left as they are.
module bdcpu_lifo_stack
  import bdcpu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);

  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level <= '0;
    end else if (push && !full) begin
      level <= level + LW'(1);
    end else if (pop && !empty) begin
      level <= level - LW'(1);
    end
  end

  // Entries are written by comparing the level against each slot so the
  // index width never has to match the level width.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !full && level == LW'(i)) begin
        mem[i] <= push_data;
      end
    end
  end

  always_comb begin
    pop_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (level == LW'(i + 1)) begin
        pop_data = mem[i];
      end
    end
  end

endmodule

// File: rtl/bdcpu_call_counter.sv
// Program counter with hardware return-address stack and sticky
// overflow/underflow flags, sitting on the shared tri-state CPU bus.
module bdcpu_call_counter
  import bdcpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int BUS_WIDTH   = BUS_WIDTH_DEFAULT,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               increment_enable,
  input  logic                               write_enable,
  input  logic                               call_enable,
  input  logic                               return_enable,
  input  logic                               output_enable,
  input  logic                               clear_flags,
  inout  wire  [BUS_WIDTH-1:0]               bus,
  output logic [ADDR_WIDTH-1:0]              pc_value,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
  output logic                               overflow,
  output logic                               underflow
);

  logic                  do_ret;
  logic                  do_call;
  logic                  do_jump;
  logic                  do_inc;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] pop_data;
  logic [BUS_WIDTH-1:0]  bus_drive;

  // Fixed priority: return > call > jump > increment, one action per edge.
  assign do_ret  = return_enable;
  assign do_call = !return_enable && call_enable;
  assign do_jump = !return_enable && !call_enable && write_enable;
  assign do_inc  = !return_enable && !call_enable && !write_enable && increment_enable;

  assign target = ADDR_WIDTH'(bus);

  bdcpu_lifo_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (do_call),
    .pop       (do_ret),
    .push_data (pc_value),
    .pop_data  (pop_data),
    .level     (stack_level),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_value <= '0;
    end else if (do_ret) begin
      if (!empty) pc_value <= pop_data;
    end else if (do_call) begin
      if (!full) pc_value <= target;
    end else if (do_jump) begin
      pc_value <= target;
    end else if (do_inc) begin
      pc_value <= pc_value + ADDR_WIDTH'(1);
    end
  end

  // A new error in the same cycle as clear_flags still leaves the flag set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !clear_flags) || (do_call && full);
      underflow <= (underflow && !clear_flags) || (do_ret && empty);
    end
  end

  always_comb begin
    bus_drive                 = '0;
    bus_drive[ADDR_WIDTH-1:0] = pc_value;
  end

  assign bus = output_enable ? bus_drive : {BUS_WIDTH{1'bz}};

endmodule

// File: tb/tb_bdcpu_call_counter.sv
// Directed bench for bdcpu_call_counter with default parameters
// (ADDR_WIDTH=4, BUS_WIDTH=8, STACK_DEPTH=4).
module tb_bdcpu_call_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       increment_enable;
  logic       write_enable;
  logic       call_enable;
  logic       return_enable;
  logic       output_enable;
  logic       clear_flags;
  logic [7:0] bus_drv;
  logic       bus_en;
  wire  [7:0] bus;
  logic [3:0] pc_value;
  logic [2:0] stack_level;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  assign bus = bus_en ? bus_drv : 8'bzzzzzzzz;

  always #5 clock = ~clock;

  bdcpu_call_counter dut (
    .clock            (clock),
    .reset            (reset),
    .increment_enable (increment_enable),
    .write_enable     (write_enable),
    .call_enable      (call_enable),
    .return_enable    (return_enable),
    .output_enable    (output_enable),
    .clear_flags      (clear_flags),
    .bus              (bus),
    .pc_value         (pc_value),
    .stack_level      (stack_level),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] pc, input logic [2:0] lvl,
                           input logic ovf, input logic udf);
    chk({tag, ".pc"}, 32'(pc_value), 32'(pc));
    chk({tag, ".lvl"}, 32'(stack_level), 32'(lvl));
    chk({tag, ".ovf"}, 32'(overflow), 32'(ovf));
    chk({tag, ".udf"}, 32'(underflow), 32'(udf));
  endtask

  task automatic idle();
    increment_enable = 0; write_enable = 0; call_enable = 0;
    return_enable = 0; output_enable = 0; clear_flags = 0;
    bus_en = 0; bus_drv = 8'h00;
  endtask

  // Apply the currently driven inputs for one rising edge, then settle.
  task automatic cyc();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic do_call(input logic [7:0] t);
    call_enable = 1; bus_en = 1; bus_drv = t;
    cyc();
  endtask

  task automatic do_ret();
    return_enable = 1;
    cyc();
  endtask

  initial begin
    idle();
    reset = 0;
    #12;
    chk_state("reset", 4'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;

    // 17 increments: 1..15, 0, 1
    for (int i = 1; i <= 17; i++) begin
      increment_enable = 1;
      cyc();
      chk($sformatf("inc%0d", i), 32'(pc_value), 32'(i % 16));
    end
    chk_state("inc_end", 4'h1, 3'd0, 1'b0, 1'b0);

    // Jump ignores upper bus bits
    write_enable = 1; bus_en = 1; bus_drv = 8'hF3;
    cyc();
    chk("jump", 32'(pc_value), 32'h3);

    // CALL then RET back-to-back
    do_call(8'h0A);
    chk_state("call1", 4'hA, 3'd1, 1'b0, 1'b0);
    do_ret();
    chk_state("ret1", 4'h3, 3'd0, 1'b0, 1'b0);

    // Fill and overflow the stack
    do_call(8'h01);
    do_call(8'h02);
    do_call(8'h03);
    do_call(8'h04);
    chk_state("call4", 4'h4, 3'd4, 1'b0, 1'b0);
    do_call(8'h05);
    chk_state("call5_ovf", 4'h4, 3'd4, 1'b1, 1'b0);
    do_ret();
    chk_state("pop_a", 4'h3, 3'd3, 1'b1, 1'b0);
    do_ret();
    chk_state("pop_b", 4'h2, 3'd2, 1'b1, 1'b0);
    do_ret();
    chk_state("pop_c", 4'h1, 3'd1, 1'b1, 1'b0);
    do_ret();
    chk_state("pop_d", 4'h3, 3'd0, 1'b1, 1'b0);
    do_ret();
    chk_state("udf", 4'h3, 3'd0, 1'b1, 1'b1);

    clear_flags = 1;
    cyc();
    chk_state("clear", 4'h3, 3'd0, 1'b0, 1'b0);

    // Priority: RET beats CALL and increment
    do_call(8'h07);
    chk_state("call7", 4'h7, 3'd1, 1'b0, 1'b0);
    return_enable = 1; call_enable = 1; increment_enable = 1;
    bus_en = 1; bus_drv = 8'h09;
    cyc();
    chk_state("prio", 4'h3, 3'd0, 1'b0, 1'b0);

    // CALL beats jump and increment
    call_enable = 1; write_enable = 1; increment_enable = 1;
    bus_en = 1; bus_drv = 8'h06;
    cyc();
    chk_state("prio_call", 4'h6, 3'd1, 1'b0, 1'b0);
    do_ret();

    // Bus drive
    write_enable = 1; bus_en = 1; bus_drv = 8'h0B;
    cyc();
    output_enable = 1;
    #1;
    chk("bus_oe", 32'(bus), 32'h0B);
    increment_enable = 1;
    #1;
    chk("bus_oe_inc_old", 32'(bus), 32'h0B);
    cyc();
    chk("pc_after_oe_inc", 32'(pc_value), 32'hC);
    output_enable = 1;
    #1;
    chk("bus_follows_pc", 32'(bus), 32'h0C);
    output_enable = 0; bus_en = 1; bus_drv = 8'h51;
    #1;
    chk("bus_released", 32'(bus), 32'h51);
    bus_en = 0;

    // Asynchronous reset between edges discards the stack
    do_call(8'h01);
    do_call(8'h02);
    chk_state("two_calls", 4'h2, 3'd2, 1'b0, 1'b0);
    #2;
    reset = 0;
    #1;
    chk_state("async_rst", 4'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1;

    // Underflow set in the same cycle as clear_flags stays set
    return_enable = 1; clear_flags = 1;
    cyc();
    chk_state("udf_vs_clear", 4'h0, 3'd0, 1'b0, 1'b1);
    clear_flags = 1;
    cyc();
    chk("udf_cleared", 32'(underflow), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bdcpu_call_counter.md
# bdcpu_call_counter

Parametrised program counter for the next-generation bdcpu. It adds a hardware return-address stack, so the control unit can execute CALL and RET in addition to increment and jump. It sits on the shared tri-state bus in place of the fixed 4-bit counter, with generic address width and stack depth. It reports overflow and underflow as sticky flags instead of silently corrupting the flow.

## Interface
- ADDR_WIDTH, 4, counter and stack entry width; 1..BUS_WIDTH
- BUS_WIDTH, 8, shared bus width
- STACK_DEPTH, 4, return-address entries; ≥1
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; one clock; polarity and synchronicity are fixed
- increment_enable  input  1  PC ← PC+1
- write_enable  input  1  jump: PC ← bus[ADDR_WIDTH-1:0]
- call_enable  input  1  push PC, then PC ← bus[ADDR_WIDTH-1:0]
- return_enable  input  1  PC ← popped entry
- output_enable  input  1  drive bus with zero-extended PC
- clear_flags  input  1  synchronous clear of the sticky flags
- bus  inout  BUS_WIDTH  shared CPU bus
- pc_value  output  ADDR_WIDTH  registered PC
- stack_level  output  $clog2(STACK_DEPTH+1)  entries in use
- overflow  output  1  sticky: CALL attempted with the stack full
- underflow  output  1  sticky: RET attempted with the stack empty

## Operation
- Reset (reset low, asynchronous) sets:
  - pc_value=0, stack_level=0, overflow=0, underflow=0.
  - Stack contents are don't-care.
- At most one action per clock. Priority: return_enable > call_enable > write_enable > increment_enable.
- Lower-priority enables asserted in the same cycle as a higher one are ignored.
- PC increment:
  - Modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH−1 wraps to 0.
  - No flag is raised on wrap.
- Jump:
  - Takes bus[ADDR_WIDTH-1:0]; upper bus bits are ignored.
- CALL:
  - Not full: the entry at index stack_level gets the current PC, stack_level increments, PC ← bus target.
  - The pushed value is the PC as it stands; the control unit has already incremented past the CALL word during fetch.
  - Full (stack_level==STACK_DEPTH): no push, PC unchanged, overflow←1.
- RET:
  - Not empty: PC ← entry at stack_level−1, stack_level decrements.
  - Empty: PC unchanged, underflow←1.
- Sticky flags:
  - clear_flags clears both flags.
  - A flag set in the same cycle as clear_flags wins (ends at 1).
- Bus drive:
  - output_enable drives {zeros, pc_value} combinationally; otherwise every bus bit is high-Z.
  - The counter never drives the bus while call_enable or write_enable is sampling it; a control-unit conflict is an error.
- Combined output_enable with increment in one cycle is legal: the bus shows the old PC and pc_value updates at the edge.

## Timing
- All state changes on the rising edge of clock. Reset is the only asynchronous path.
- pc_value, stack_level and the flags reflect an action one edge after the enable is sampled high.
- Bus output has zero-cycle latency from output_enable and from pc_value.
- Back-to-back CALL/RET on consecutive cycles is supported with no bubbles.
- A RET immediately after a CALL returns to the pushed address.
- Reset asserted mid-sequence discards the whole stack immediately.

## Structure
- Shared package/header bdcpu_pkg holds:
  - opcode constants OP_CALL=4'b1001 and OP_RET=4'b1010, consumed by bdcpu_control;
  - default BUS_WIDTH.
- Sub-module bdcpu_lifo_stack, parametrised by WIDTH and DEPTH:
  - ports: push, pop, push_data, pop_data, level, full, empty;
  - same clock/reset, level reset to 0.
- The counter wrapper owns the PC register, priority decode, flags and the bus tri-state.

## Test plan
- Reset, then 17 increments with ADDR_WIDTH=4 → pc_value 0..15 then 1. No flags set.
- PC=3, bus=0x0A, call_enable → pc_value=0xA, stack_level=1. Then return_enable → pc_value=3, stack_level=0.
- STACK_DEPTH=4: five CALLs to 1,2,3,4,5 → fifth call leaves PC=4, stack_level=4, overflow=1. Four RETs return 3,2,1,original. A fifth RET sets underflow=1 with PC unchanged.
- return_enable+call_enable+increment_enable together with one entry on the stack → only the pop occurs. pc_value equals the popped address.
- output_enable with PC=0xB, BUS_WIDTH=8 → bus=0x0B. output_enable low → bus all Z.
- Two CALLs pending, reset pulsed low between edges → immediate pc_value=0, stack_level=0. clear_flags in the same cycle as an underflow RET → underflow=1.
